// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - state encoding shared by the sequencer, video and control blocks
package game_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_HIT       = 3'd3,
    ST_OVER      = 3'd4
  } state_e;

endpackage

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - key/sync inputs and sequencing outputs of the game sequencer
interface game_sequencer_if;
  import game_pkg::*;

  logic               key_start;
  logic               key_flap;
  logic               vsync;
  logic               collision;
  logic               frame_tick;
  logic               game_rst;
  logic               play_en;
  logic               flap;
  logic               start_num0;
  logic               start_num1;
  logic               start_num2;
  logic [1:0]         countdown;
  logic [STATE_W-1:0] state;

  modport master (
    input  key_start, key_flap, vsync, collision,
    output frame_tick, game_rst, play_en, flap,
    output start_num0, start_num1, start_num2, countdown, state
  );

  modport slave (
    output key_start, key_flap, vsync, collision,
    input  frame_tick, game_rst, play_en, flap,
    input  start_num0, start_num1, start_num2, countdown, state
  );

endinterface

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - one-cycle frame pulse on the inactive-to-active vsync transition
module frame_tick_gen #(
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic clk,
  input  logic Rst,
  input  logic vsync,
  output logic frame_tick
);

  logic active;
  logic act_q, act_d;
  logic armed_q, armed_d;
  logic tick_q, tick_d;

  assign active = (vsync == VSYNC_POL);

  // armed_q blocks a tick when vsync is already active as reset releases
  always_comb begin
    act_d   = active;
    armed_d = armed_q | ~active;
    tick_d  = active & ~act_q & armed_q;
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      act_q   <= 1'b0;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      act_q   <= act_d;
      armed_q <= armed_d;
      tick_q  <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game state machine: countdown, staggered pipe starts, hit freeze, game over
module game_sequencer
  import game_pkg::*;
#(
  parameter int COUNT_FRAMES    = 60,
  parameter int PIPE_GAP_FRAMES = 90,
  parameter int HIT_FRAMES      = 30,
  parameter bit VSYNC_POL       = 1'b1
) (
  input logic               clk,
  input logic               Rst,
  game_sequencer_if.master  bus
);

  localparam logic [7:0] CNT_LAST = 8'(COUNT_FRAMES - 1);
  localparam logic [7:0] HIT_LAST = 8'(HIT_FRAMES - 1);
  localparam logic [7:0] GAP1     = 8'(PIPE_GAP_FRAMES);
  localparam logic [7:0] GAP2     = 8'(2 * PIPE_GAP_FRAMES);

  logic       tick;
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] stag_q, stag_d;
  logic [1:0] cd_q, cd_d;
  logic       s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic       game_rst_q, game_rst_d;
  logic       play_en_q, play_en_d;
  logic       flap_q, flap_d;

  frame_tick_gen #(.VSYNC_POL(VSYNC_POL)) u_tick (
    .clk        (clk),
    .Rst        (Rst),
    .vsync      (bus.vsync),
    .frame_tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stag_d     = stag_q;
    cd_d       = cd_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    game_rst_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.key_start) begin
          state_d    = ST_COUNTDOWN;
          game_rst_d = 1'b1;
          cd_d       = 2'd3;
          cnt_d      = 8'd0;
          stag_d     = 8'd0;
          s0_d       = 1'b0;
          s1_d       = 1'b0;
          s2_d       = 1'b0;
        end
      end
      ST_COUNTDOWN: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = 8'd0;
            if (cd_q == 2'd1) begin
              state_d = ST_PLAY;
              cd_d    = 2'd0;
              s0_d    = 1'b1;
            end else begin
              cd_d = cd_q - 2'd1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_PLAY: begin
        // collision takes priority over a coincident frame tick
        if (bus.collision) begin
          state_d = ST_HIT;
          cnt_d   = 8'd0;
        end else if (tick && !s2_q) begin
          stag_d = stag_q + 8'd1;
          if (stag_d == GAP1) s1_d = 1'b1;
          if (stag_d == GAP2) s2_d = 1'b1;
        end
      end
      ST_HIT: begin
        if (tick) begin
          if (cnt_q == HIT_LAST) begin
            state_d = ST_OVER;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cd_d    = 2'd0;
      end
    endcase
    play_en_d = (state_d == ST_PLAY);
    flap_d    = bus.key_flap && (state_q == ST_PLAY);
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      stag_q     <= 8'd0;
      cd_q       <= 2'd0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      game_rst_q <= 1'b0;
      play_en_q  <= 1'b0;
      flap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stag_q     <= stag_d;
      cd_q       <= cd_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      game_rst_q <= game_rst_d;
      play_en_q  <= play_en_d;
      flap_q     <= flap_d;
    end
  end

  assign bus.frame_tick = tick;
  assign bus.game_rst   = game_rst_q;
  assign bus.play_en    = play_en_q;
  assign bus.flap       = flap_q;
  assign bus.start_num0 = s0_q;
  assign bus.start_num1 = s1_q;
  assign bus.start_num2 = s2_q;
  assign bus.countdown  = cd_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed vector bench for game_sequencer with short frame timing
module tb_game_sequencer;

  logic clk = 1'b0;
  logic Rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  game_sequencer_if bus();

  game_sequencer #(
    .COUNT_FRAMES    (2),
    .PIPE_GAP_FRAMES (3),
    .HIT_FRAMES      (2),
    .VSYNC_POL       (1'b1)
  ) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

  typedef struct {
    bit         ks;
    bit         kf;
    bit         col;
    int         frames;
    logic [2:0] st;
    logic [1:0] cd;
    logic [2:0] sn;
    logic       pe;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] snap();
    return {bus.state, bus.countdown, bus.start_num0, bus.start_num1, bus.start_num2, bus.play_en};
  endfunction

  // one 20-cycle vsync period; optional collision aligned with the frame_tick cycle
  task automatic frame(input bit col_on_tick);
    bus.vsync = 1'b1;
    @(posedge clk); @(negedge clk);
    check("frame_tick_pulse", 32'(bus.frame_tick), 32'd1);
    bus.collision = col_on_tick;
    @(posedge clk); @(negedge clk);
    bus.collision = 1'b0;
    check("frame_tick_width", 32'(bus.frame_tick), 32'd0);
    bus.vsync = 1'b0;
    repeat (18) @(negedge clk);
  endtask

  task automatic pulse(input bit ks, input bit kf, input bit col);
    bus.key_start = ks;
    bus.key_flap  = kf;
    bus.collision = col;
    @(posedge clk); @(negedge clk);
    bus.key_start = 1'b0;
    bus.key_flap  = 1'b0;
    bus.collision = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    bit saw;
    vecs[0]  = '{0, 0, 0, 0, 3'd0, 2'd0, 3'b000, 1'b0};
    vecs[1]  = '{0, 0, 1, 1, 3'd0, 2'd0, 3'b000, 1'b0};
    vecs[2]  = '{1, 0, 0, 0, 3'd1, 2'd3, 3'b000, 1'b0};
    vecs[3]  = '{0, 0, 0, 1, 3'd1, 2'd3, 3'b000, 1'b0};
    vecs[4]  = '{0, 0, 0, 1, 3'd1, 2'd2, 3'b000, 1'b0};
    vecs[5]  = '{0, 0, 0, 2, 3'd1, 2'd1, 3'b000, 1'b0};
    vecs[6]  = '{1, 0, 0, 1, 3'd1, 2'd1, 3'b000, 1'b0};
    vecs[7]  = '{0, 0, 0, 1, 3'd2, 2'd0, 3'b100, 1'b1};
    vecs[8]  = '{0, 0, 0, 2, 3'd2, 2'd0, 3'b100, 1'b1};
    vecs[9]  = '{0, 0, 0, 1, 3'd2, 2'd0, 3'b110, 1'b1};
    vecs[10] = '{0, 0, 0, 2, 3'd2, 2'd0, 3'b110, 1'b1};
    vecs[11] = '{0, 0, 0, 1, 3'd2, 2'd0, 3'b111, 1'b1};
    vecs[12] = '{0, 0, 0, 3, 3'd2, 2'd0, 3'b111, 1'b1};
    vecs[13] = '{0, 0, 1, 0, 3'd3, 2'd0, 3'b111, 1'b0};
    vecs[14] = '{1, 0, 0, 1, 3'd3, 2'd0, 3'b111, 1'b0};
    vecs[15] = '{0, 0, 0, 1, 3'd4, 2'd0, 3'b111, 1'b0};
    vecs[16] = '{1, 0, 0, 0, 3'd1, 2'd3, 3'b000, 1'b0};

    Rst = 1'b0;
    bus.key_start = 1'b0;
    bus.key_flap  = 1'b0;
    bus.vsync     = 1'b0;
    bus.collision = 1'b0;
    repeat (3) @(negedge clk);
    Rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_frame_tick", 32'(bus.frame_tick), 32'd0);
    check("reset_game_rst", 32'(bus.game_rst), 32'd0);
    check("reset_flap", 32'(bus.flap), 32'd0);

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].ks || vecs[i].kf || vecs[i].col)
        pulse(vecs[i].ks, vecs[i].kf, vecs[i].col);
      repeat (vecs[i].frames) frame(1'b0);
      check($sformatf("vec%0d", i), 32'(snap()),
            32'({vecs[i].st, vecs[i].cd, vecs[i].sn, vecs[i].pe}));
    end

    // collision coincident with the second PLAY tick
    repeat (6) frame(1'b0);
    check("play_entry", 32'(snap()), 32'({3'd2, 2'd0, 3'b100, 1'b1}));
    frame(1'b0);
    frame(1'b1);
    check("hit_on_tick", 32'(snap()), 32'({3'd3, 2'd0, 3'b100, 1'b0}));
    frame(1'b0);
    check("hit_hold", 32'(snap()), 32'({3'd3, 2'd0, 3'b100, 1'b0}));
    frame(1'b0);
    check("over_s1_low", 32'(snap()), 32'({3'd4, 2'd0, 3'b100, 1'b0}));

    // start and flap together in OVER, then flap gating
    pulse(1'b1, 1'b1, 1'b0);
    check("restart_game_rst", 32'(bus.game_rst), 32'd1);
    check("restart_flap", 32'(bus.flap), 32'd0);
    check("restart_state", 32'(bus.state), 32'd1);
    @(negedge clk);
    check("game_rst_width", 32'(bus.game_rst), 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    check("flap_countdown", 32'(bus.flap), 32'd0);
    repeat (6) frame(1'b0);
    check("play_again", 32'(bus.state), 32'd2);
    pulse(1'b0, 1'b1, 1'b0);
    check("flap_play", 32'(bus.flap), 32'd1);
    @(negedge clk);
    check("flap_width", 32'(bus.flap), 32'd0);

    // asynchronous reset in PLAY with vsync held active across release
    #2 Rst = 1'b0;
    #1;
    check("async_rst_outputs", 32'(snap()), 32'd0);
    check("async_rst_flags", 32'({bus.frame_tick, bus.game_rst, bus.flap}), 32'd0);
    @(negedge clk);
    bus.vsync = 1'b1;
    @(negedge clk);
    Rst = 1'b1;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.frame_tick) saw = 1'b1;
    end
    check("no_tick_after_reset", 32'(saw), 32'd0);
    bus.vsync = 1'b0;
    @(negedge clk);
    frame(1'b0);
    check("idle_after_reset", 32'(snap()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter COUNT_FRAMES, default 60: frames per countdown digit (1..255).
REQ-002 SHALL have parameter PIPE_GAP_FRAMES, default 90: frames between successive pipe starts (1..127).
REQ-003 SHALL have parameter HIT_FRAMES, default 30: frames frozen after collision before OVER (1..255).
REQ-004 SHALL have parameter VSYNC_POL, default 1: active level of vsync.
REQ-005 Ports (name, direction, width, meaning):
 clk  in  1  pixel clock; sole clock.
 Rst  in  1  asynchronous, active-low reset.
 key_start  in  1  debounced one-cycle start pulse.
 key_flap  in  1  debounced one-cycle flap pulse.
 vsync  in  1  field sync from the HDMI driver, clk domain.
 collision  in  1  level from the game-control block; high = bird hit.
 frame_tick  out  1  one-cycle pulse per frame.
 game_rst  out  1  one-cycle active-high reset pulse to pipes/random/bird.
 play_en  out  1  high only in PLAY; motion enable.
 flap  out  1  gated flap pulse.
 start_num0/1/2  out  1 each  pipe-slot start levels.
 countdown  out  2  digit shown during COUNTDOWN (3..1), else 0.
 state  out  3  current state encoding.

Function
REQ-006 SHALL assert frame_tick for exactly one cycle, the cycle after vsync is first sampled at its active level (registered edge detect).
REQ-007 SHALL implement states IDLE=0, COUNTDOWN=1, PLAY=2, HIT=3, OVER=4; all outputs registered.
REQ-008 IDLE or OVER + key_start: next cycle state=COUNTDOWN, game_rst=1 for one cycle, countdown=3, frame counter=0, start_num0..2=0.
REQ-009 COUNTDOWN: frame counter increments per frame_tick; at COUNT_FRAMES it clears and countdown decrements; when countdown=1 expires, state=PLAY, countdown=0.
REQ-010 PLAY entry: start_num0=1 the same cycle state becomes PLAY; start_num1=1 after PIPE_GAP_FRAMES frame_ticks; start_num2=1 after 2*PIPE_GAP_FRAMES; start levels stay high until next game_rst.
REQ-011 Stagger counter SHALL be 8 bits, saturating after start_num2 is set; SHALL not advance outside PLAY.
REQ-012 PLAY + collision=1: next cycle state=HIT, play_en=0, frame counter cleared; start_num levels held.
REQ-013 HIT: after HIT_FRAMES frame_ticks, state=OVER.
REQ-014 flap SHALL equal key_flap delayed one cycle, only while state=PLAY; suppressed otherwise.
REQ-015 key_start in COUNTDOWN, PLAY or HIT SHALL be ignored; collision outside PLAY SHALL be ignored.
REQ-016 Same-cycle collision and frame_tick in PLAY: collision wins; no stagger advance.
REQ-017 Same-cycle key_start and key_flap in OVER: restart per REQ-008; flap stays 0.
REQ-018 Illegal state encodings SHALL return to IDLE next cycle.

Reset
REQ-019 Rst low SHALL asynchronously force state=IDLE and all outputs (frame_tick, game_rst, play_en, flap, start_num0..2, countdown) to 0, counters to 0, vsync history register to the inactive level.
REQ-020 Rst deassertion mid-frame SHALL not produce a frame_tick unless vsync subsequently goes active.

Structure
REQ-021 State encodings and the state width SHALL live in shared package game_pkg for use by video and control blocks.
REQ-022 Frame edge detector SHALL be a sub-module frame_tick_gen (clk, Rst, vsync, frame_tick), parameterised by VSYNC_POL.
REQ-023 Block SHALL replace the standalone pipe-delay block; start_num0..2 drive pipe slots directly.

Verification (COUNT_FRAMES=2, PIPE_GAP_FRAMES=3, HIT_FRAMES=2, vsync period 20 clk)
REQ-024 Reset then key_start -> game_rst one-cycle pulse, state=1, countdown 3->2->1 every 2 ticks, PLAY after 6 ticks with start_num0=1.
REQ-025 In PLAY, no collision -> start_num1 rises on 3rd tick, start_num2 on 6th; both remain 1.
REQ-026 Collision coincident with frame_tick on tick 2 of PLAY -> HIT next cycle, start_num1 never rises, OVER after 2 more ticks.
REQ-027 key_flap in COUNTDOWN and OVER -> flap=0; key_flap in PLAY -> flap=1 one cycle later.
REQ-028 Rst pulsed low during PLAY -> all outputs 0 immediately, state=IDLE; key_start during HIT -> ignored.
